// File: rtl/dds_pkg.sv
// Shared widths, reset defaults and FSM encoding for the DDS SPI tuner.
package dds_pkg;
  localparam int FW_W_DEF   = 32;
  localparam int PW_W_DEF   = 16;
  localparam int FRAME_BITS = FW_W_DEF + PW_W_DEF;

  // About a 5 kHz tone out of reset.
  localparam logic [31:0] FWORD_RST_DEF = 32'd858994;
  localparam logic [15:0] PWORD_RST_DEF = 16'd0;

  typedef enum logic {IDLE, SHIFT} state_t;
endpackage

// File: rtl/sync_edge.sv
// Two-flop synchronizer plus history flop; reports level and edges in clk domain.
module sync_edge #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);
  logic s1, s2, hist;

  // Synchronize the async pin and keep one cycle of history for edge detect.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1   <= RST_VAL;
      s2   <= RST_VAL;
      hist <= RST_VAL;
    end else begin
      s1   <= din;
      s2   <= s1;
      hist <= s2;
    end
  end

  assign level = s2;
  assign rise  = s2 & ~hist;
  assign fall  = ~s2 & hist;
endmodule

// File: rtl/dds_spi_tuner.sv
// SPI mode-0 slave that loads FWORD/PWORD atomically and reads the active pair back on MISO.
module dds_spi_tuner
  import dds_pkg::*;
#(
  parameter int              FW_W      = FW_W_DEF,
  parameter int              PW_W      = PW_W_DEF,
  parameter logic [FW_W-1:0] FWORD_RST = FW_W'(FWORD_RST_DEF),
  parameter logic [PW_W-1:0] PWORD_RST = PW_W'(PWORD_RST_DEF)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            spi_sck,
  input  logic            spi_cs_n,
  input  logic            spi_mosi,
  output logic            spi_miso,
  output logic [FW_W-1:0] FWORD,
  output logic [PW_W-1:0] PWORD,
  output logic            update,
  output logic            frame_err
);
  localparam int NBITS = FW_W + PW_W;
  // Counter saturates one past a full frame so oversize frames stay distinguishable.
  localparam int CNT_W = $clog2(NBITS + 2);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(NBITS);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(NBITS + 1);

  logic sck_rise, sck_fall, sck_unused_lvl;
  logic cs_rise, cs_fall, cs_unused_lvl;
  logic mosi, mosi_unused_rise, mosi_unused_fall;

  // cs_n resets to "selected" so a select already low at reset release never opens a frame.
  sync_edge #(.RST_VAL(1'b0)) u_sck (
    .clk(clk), .rst_n(rst_n), .din(spi_sck),
    .level(sck_unused_lvl), .rise(sck_rise), .fall(sck_fall));
  sync_edge #(.RST_VAL(1'b0)) u_cs (
    .clk(clk), .rst_n(rst_n), .din(spi_cs_n),
    .level(cs_unused_lvl), .rise(cs_rise), .fall(cs_fall));
  sync_edge #(.RST_VAL(1'b0)) u_mosi (
    .clk(clk), .rst_n(rst_n), .din(spi_mosi),
    .level(mosi), .rise(mosi_unused_rise), .fall(mosi_unused_fall));

  state_t           state, state_nxt;
  logic             commit, reject;
  logic [NBITS-1:0] rx_sh, tx_sh;
  logic [CNT_W-1:0] bit_cnt;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state; a frame closes on cs_n rise and is accepted only at exactly NBITS.
  always_comb begin
    state_nxt = state;
    commit    = 1'b0;
    reject    = 1'b0;
    case (state)
      IDLE:  if (cs_fall) state_nxt = SHIFT;
      SHIFT: if (cs_rise) begin
        state_nxt = IDLE;
        if (bit_cnt == CNT_FULL) commit = 1'b1;
        else                     reject = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Shift registers, bit counter and the atomic output commit.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      FWORD     <= FWORD_RST;
      PWORD     <= PWORD_RST;
      update    <= 1'b0;
      frame_err <= 1'b0;
      rx_sh     <= '0;
      tx_sh     <= '0;
      bit_cnt   <= '0;
    end else begin
      update    <= commit;
      frame_err <= reject;
      if (commit) begin
        FWORD <= rx_sh[NBITS-1:PW_W];
        PWORD <= rx_sh[PW_W-1:0];
      end
      if (state == IDLE && cs_fall) begin
        bit_cnt <= '0;
        tx_sh   <= {FWORD, PWORD};
      end else if (state == SHIFT && !cs_rise) begin
        // cs_n rise wins over a coincident sck edge.
        if (sck_rise) begin
          rx_sh <= {rx_sh[NBITS-2:0], mosi};
          if (bit_cnt != CNT_SAT) bit_cnt <= bit_cnt + 1'b1;
        end
        if (sck_fall) tx_sh <= {tx_sh[NBITS-2:0], 1'b0};
      end
    end
  end

  assign spi_miso = (state == SHIFT) & tx_sh[NBITS-1];
endmodule

// File: doc/dds_spi_tuner.md
Name: dds_spi_tuner

Overview:
- Upstream control stage for the DDS phase-accumulator/address generator: receives tuning frames over a 4-wire SPI slave (mode 0) and drives its FWORD and PWORD inputs.
- Both words are committed in the same clock cycle, so the accumulator never sees a torn frequency/phase pair.
- Clock-domain crossing: SPI pins are oversampled in the system clock domain. spi_sck must be at most clk/4.
- Readback: the currently active words are shifted out on MISO during each frame.

Parameters:
- FW_W, 32, frequency word width
- PW_W, 16, phase word width
- FWORD_RST, 858994, FWORD value after reset (about 5 kHz tone)
- PWORD_RST, 0, PWORD value after reset

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset; synchronous, active-low
- spi_sck  in  1  SPI clock, asynchronous to clk
- spi_cs_n  in  1  SPI chip select, active-low, asynchronous
- spi_mosi  in  1  SPI data in, MSB first
- spi_miso  out  1  readback data, MSB first
- FWORD  out  FW_W  active frequency word to the DDS
- PWORD  out  PW_W  active phase word to the DDS
- update  out  1  1-cycle pulse; FWORD/PWORD changed on this edge
- frame_err  out  1  1-cycle pulse; frame rejected

Behaviour:
- Constant: FRAME_BITS = FW_W + PW_W (48).
- Synchronizers:
  - spi_sck, spi_cs_n and spi_mosi each pass through a 2-flop synchronizer, then one edge-history flop.
  - cs_n sync and history flops reset to 0 (selected). A frame can only start after high then low is observed. A chip select already low at reset release is ignored until it returns high.
  - sck flops reset to 0.
- Reset values: FWORD=FWORD_RST, PWORD=PWORD_RST, update=0, frame_err=0, spi_miso=0, state=IDLE, bit counter=0.
- FSM states: IDLE, SHIFT.
  - IDLE, cs_n fall detected: clear bit counter; load tx shift reg with {FWORD,PWORD}; go to SHIFT.
  - SHIFT, sck rise detected: rx_sh <= {rx_sh[FRAME_BITS-2:0], mosi_sync}. The bit counter increments and saturates at FRAME_BITS+1, so oversized frames stay detectable.
  - SHIFT, sck fall detected: tx shift reg shifts left by 1.
  - SHIFT, cs_n rise detected, count == FRAME_BITS: FWORD <= rx_sh[47:16], PWORD <= rx_sh[15:0], update=1 on that same edge; go to IDLE.
  - SHIFT, cs_n rise detected, count != FRAME_BITS: frame_err=1 for one cycle; outputs unchanged; go to IDLE.
- spi_miso = tx_sh[FRAME_BITS-1] while state==SHIFT, else 0.
- Latency: the commit edge is 3 clk after the spi_cs_n rising edge is first sampled (2 sync stages + 1 detect/commit).
- Simultaneous events: if sck rise and cs_n rise are detected in the same cycle, cs_n takes precedence and the sck edge is discarded.
- A cs_n fall detected while in SHIFT cannot occur. No special handling is required.
- update and frame_err are never asserted together.
- Reset mid-frame: the partial frame is discarded and outputs return to the reset values. The next frame is accepted only after cs_n is seen high, then low.
- Between commits FWORD/PWORD are held; no intermediate values are ever visible.

Decomposition:
- Shared package dds_pkg:
  - FW_W/PW_W defaults and FRAME_BITS
  - FWORD_RST/PWORD_RST defaults
  - FSM state enum {IDLE, SHIFT}
- One sub-module, sync_edge:
  - parameter RST_VAL
  - 2-flop synchronizer plus history flop
  - outputs: level, rise, fall
- Instantiated three times (sck, cs_n, mosi); the mosi instance uses level only.

Test Plan:
- Reset -> FWORD=858994, PWORD=0, update=0, frame_err=0, miso=0. Hold cs_n low through reset release and clock 48 bits -> no update, no frame_err.
- 48-bit frame 0xC5B05C05_0800 at sck=clk/8 -> exactly one update pulse 3 clk after cs_n rise is sampled; FWORD=0xC5B05C05, PWORD=0x0800 on that edge.
- 47-bit frame -> one frame_err pulse, no update, outputs unchanged. Repeat with 50 bits -> same result.
- Readback: commit 0x12345678_9ABC, then send any 48-bit frame -> miso bits on sck rising edges equal 0x123456789ABC, MSB first.
- Assert rst_n low at bit 20 of a frame, cs_n still low -> outputs go to reset values, no pulses. Drive cs_n high then send a full frame 0x00000001_FFFF -> update, FWORD=1, PWORD=0xFFFF.
- Back-to-back frames, cs_n high for 4 clk between them, payloads 0xAAAAAAAA_5555 then 0x55555555_AAAA -> two update pulses, final values 0x55555555/0xAAAA.
